// File: rtl/sd_pkg.sv
// Shared types and digit encodings for the signed-digit on-the-fly converter.
package sd_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } sd_state_e;

    // Digit encoding is {plus, minus}; 2'b11 also decodes as zero.
    localparam logic [1:0] SD_POS  = 2'b10;
    localparam logic [1:0] SD_NEG  = 2'b01;
    localparam logic [1:0] SD_ZERO = 2'b00;

endpackage

// File: rtl/otf_digit_step.sv
// One on-the-fly conversion step: selects and left-shifts Q/QM for one signed digit.
module otf_digit_step
    import sd_pkg::*;
#(
    parameter int unsigned Width = 65
) (
    input  logic [Width-1:0] q_i,
    input  logic [Width-1:0] qm_i,
    input  logic [1:0]       digit_i,
    output logic [Width-1:0] q_o,
    output logic [Width-1:0] qm_o
);

    always_comb begin
        q_o  = {q_i[Width-2:0], 1'b0};
        qm_o = {qm_i[Width-2:0], 1'b1};
        case (digit_i)
            SD_POS: begin
                q_o  = {q_i[Width-2:0], 1'b1};
                qm_o = {q_i[Width-2:0], 1'b0};
            end
            SD_NEG: begin
                q_o  = {qm_i[Width-2:0], 1'b1};
                qm_o = {qm_i[Width-2:0], 1'b0};
            end
            default: begin
                q_o  = {q_i[Width-2:0], 1'b0};
                qm_o = {qm_i[Width-2:0], 1'b1};
            end
        endcase
    end

endmodule

// File: rtl/sd_otf_converter.sv
// Serial MSB-first signed-digit to two's-complement converter with a
// ready/valid output word held until consumed.
module sd_otf_converter
    import sd_pkg::*;
#(
    parameter int unsigned bits = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          in_valid,
    input  logic          in_plus,
    input  logic          in_minus,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [bits:0] out_value,
    output logic          out_zero
);

    localparam int unsigned Width = bits + 1;
    localparam int unsigned CntW  = (bits > 1) ? $clog2(bits) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(bits - 1);

    sd_state_e       state_q, state_d;
    logic [Width-1:0] q_q, q_d;
    logic [Width-1:0] qm_q, qm_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic [Width-1:0] q_step;
    logic [Width-1:0] qm_step;

    otf_digit_step #(
        .Width (Width)
    ) u_step (
        .q_i     (q_q),
        .qm_i    (qm_q),
        .digit_i ({in_plus, in_minus}),
        .q_o     (q_step),
        .qm_o    (qm_step)
    );

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        qm_d    = qm_q;
        cnt_d   = cnt_q;
        if (clr) begin
            state_d = ACCUM;
            q_d     = '0;
            qm_d    = '1;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (in_valid) begin
                        q_d  = q_step;
                        qm_d = qm_step;
                        if (cnt_q == LastCnt) begin
                            cnt_d   = '0;
                            state_d = HOLD;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    // Re-arm in the same edge the result is consumed.
                    if (out_ready) begin
                        state_d = ACCUM;
                        q_d     = '0;
                        qm_d    = '1;
                        cnt_d   = '0;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCUM;
            q_q     <= '0;
            qm_q    <= '1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            qm_q    <= qm_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == HOLD);
    assign out_value = q_q;
    assign out_zero  = (q_q == '0);

endmodule

// File: doc/sd_otf_converter.md
SD_OTF_CONVERTER -- requirements
Module: sd_otf_converter

Interface
REQ-001 Parameter: bits, default 64, number of signed digits per word.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 clr  input  1  synchronous abort of the current word; active-high.
REQ-005 in_valid  input  1  digit present on in_plus/in_minus.
REQ-006 in_plus  input  1  positive rail of the signed digit.
REQ-007 in_minus  input  1  negative rail of the signed digit.
REQ-008 in_ready  output  1  converter accepts a digit this cycle.
REQ-009 out_valid  output  1  out_value holds a completed word.
REQ-010 out_ready  input  1  consumer takes out_value this cycle.
REQ-011 out_value  output  bits+1  two's-complement result of the converted word.
REQ-012 out_zero  output  1  out_value equals zero; meaningful only while out_valid=1.

Function
REQ-013 Digit value d = in_plus - in_minus; (0,0) and (1,1) both give d=0.
REQ-014 Digits arrive most-significant first: digit k (k=0..bits-1) has weight 2^(bits-1-k); word value = sum of d_k*2^(bits-1-k), range -(2^bits-1)..+(2^bits-1).
REQ-015 On-the-fly conversion: registers Q and QM, each bits+1 wide, with invariant QM = Q-1 after every accepted digit.
REQ-016 At word start: Q = 0, QM = all ones.
REQ-017 Per accepted digit, d=+1: Q <= {Q,1}, QM <= {Q,0}.
REQ-018 Per accepted digit, d=0: Q <= {Q,0}, QM <= {QM,1}.
REQ-019 Per accepted digit, d=-1: Q <= {QM,1}, QM <= {QM,0}. All appends are left shifts that drop the MSB.
REQ-020 No carry-propagate adder on the digit path; each update is a selection and shift only.
REQ-021 States: ACCUM and HOLD. In ACCUM, in_ready=1 and out_valid=0. In HOLD, in_ready=0 and out_valid=1.
REQ-022 A digit is accepted when in_valid && in_ready. A digit counter (0..bits-1) advances on each accepted digit.
REQ-023 ACCUM->HOLD on acceptance of digit bits-1; out_value = final Q is valid the next cycle (latency 1 cycle after the last digit).
REQ-024 HOLD->ACCUM when out_ready=1: Q, QM and the counter re-initialise in that same edge, and in_ready=1 the following cycle.
REQ-025 While out_valid=1 and out_ready=0: out_value, out_zero and out_valid hold stable; input digits are not accepted.
REQ-026 in_valid=0 in ACCUM: no state change (gaps between digits allowed).
REQ-027 clr=1: from any state, return to ACCUM with re-initialised Q, QM and counter, and out_valid=0 next cycle; clr has priority over digit acceptance and out_ready.
REQ-028 out_value is driven directly from the Q register, with no combinational path from the inputs.

Reset
REQ-029 rst=1 at a clock edge sets: state=ACCUM, counter=0, Q=0, QM=all ones, out_valid=0, out_value=0, out_zero=1 (don't-care while invalid).
REQ-030 rst has priority over clr and over all handshakes; a word in progress is discarded.

Structure
REQ-031 Shared package sd_pkg holds the state enum (ACCUM, HOLD) and the digit-encoding constants (SD_POS=2'b10, SD_NEG=2'b01, SD_ZERO=2'b00).
REQ-032 One sub-module, otf_digit_step (combinational, width bits+1), takes Q, QM and the digit and returns next Q and next QM; the top instantiates it once.
REQ-033 Estimated size: 120-250 lines total.

Verification (bench uses bits=4, out_value 5 bits)
REQ-034 Digits +1,0,-1,+1 back-to-back -> out_valid one cycle after the 4th digit, out_value=5'b00111 (7).
REQ-035 Digits -1,-1,-1,-1 -> out_value=5'b10001 (-15); digits +1,-1,-1,-1 -> 5'b00001 (1).
REQ-036 Digits (1,1),(0,0),(1,1),(0,0) -> out_value=0 and out_zero=1.
REQ-037 Hold out_ready=0 for 5 cycles after completion, keeping in_valid=1 -> in_ready=0, out_value stable, no digit consumed; the next word converts correctly after out_ready=1.
REQ-038 Assert rst (or clr) after 2 digits, then send a full word +1,+1,+1,+1 -> out_value=5'b01111 (15), with no residue from the aborted word.
